sha256_compress: RTL and testbench
==================================

// Module: sha256_compress
// PURPOSE
//  SHA-256 compression stage, directly downstream of the message-expansion block.
//  Consumes the W_t word stream (t = 0..63) one word per accepted cycle.
//  Runs the 64 compression rounds on working registers a..h.
//  Adds the result into the chaining value H0..H7 and presents a 256-bit digest.
//  Supports multi-block messages: each block is chained from the previous H, or restarts from the IV.
// PARAMETERS
//  DATA_WIDTH  32  word width; only 32 is legal (SHA-256 arithmetic is mod 2^32)
// PORTS
//  clk               in   1    clock
//  rst_n             in   1    reset, asynchronous, active-low
//  start_in          in   1    begin a block; sampled only in IDLE
//  init_in           in   1    with start_in: 1 = load IV into H first, 0 = chain from current H
//  w_valid_in        in   1    w_in carries W_t this cycle; sampled only in ROUNDS
//  w_in              in   32   message-schedule word W_t
//  busy_out          out  1    high in ROUNDS and FINAL
//  round_out         out  6    index t of the next word expected
//  digest_valid_out  out  1    one-cycle pulse: digest_out updated
//  digest_out        out  256  {H0,H1,...,H7}, H0 in bits [255:224]
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; busy_out = 0; round_out = 0; digest_valid_out = 0; digest_out = 0.
//   - H0..H7 = SHA-256 IV (6a09e667 ... 5be0cd19); a..h = 0.
//  FSM: IDLE -> ROUNDS -> FINAL -> IDLE.
//  IDLE, start_in = 1 at edge N:
//   - If init_in = 1: H <= IV and a..h <= IV.
//   - Else: a..h <= H.
//   - t <= 0; state <= ROUNDS.
//   - w_valid_in is ignored while in IDLE.
//  ROUNDS, edge with w_valid_in = 1:
//   - T1 = h + S1(e) + Ch(e,f,g) + K[t] + w_in; T2 = S0(a) + Maj(a,b,c); all sums mod 2^32.
//   - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2; t<=t+1.
//   - S0 = ROTR2 ^ ROTR13 ^ ROTR22; S1 = ROTR6 ^ ROTR11 ^ ROTR25.
//   - Ch = (e&f) ^ (~e&g); Maj = (a&b) ^ (a&c) ^ (b&c).
//   - K[0..63] comes from an internal constant table indexed by t.
//  ROUNDS, w_valid_in = 0: stall; all registers hold, no timeout.
//  Word for t = 63 accepted at edge M: state <= FINAL; t wraps to 0.
//  FINAL, edge M+1:
//   - Hi <= Hi + working reg i (mod 2^32); digest_out <= the new H.
//   - digest_valid_out = 1 for the single cycle after edge M+1.
//   - state <= IDLE.
//  Latency: digest valid 2 cycles after the last word, 66 cycles after start with no stalls.
//  digest_out holds its value until the next FINAL.
//  start_in while busy_out = 1: ignored; the block in progress is unaffected.
//  start_in in the pulse cycle (IDLE): accepted normally; the next block chains from the new H.
//  rst_n asserted mid-block: immediately returns to reset values; the partial block is discarded.
// CONFIGURATION
//  SHA224_EN defined:
//   - Adds port mode_224_in (in, 1), sampled together with start_in && init_in.
//   - mode_224_in = 1 loads the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939
//     ffc00b31 68581511 64f98fa7 befa4fa4); otherwise the SHA-256 IV.
//   - digest_out[31:0] still carries H7; the consumer truncates to 224 bits.
//  SHA224_EN undefined: no mode_224_in port; the SHA-256 IV only.
// TESTING
//  - Reset: after rst_n release, digest_out=0, busy_out=0, round_out=0, digest_valid_out=0.
//  - "abc" (init=1; W0..15 = 61626380, 0 x14, 00000018, plus ME-expanded W16..63, no stalls)
//    -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad,
//       pulse at cycle 66.
//  - Empty message (W0 = 80000000, rest 0, expanded)
//    -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  - Random w_valid_in gaps on the "abc" stream -> same digest; round_out only advances on valid.
//  - Two-block 56-byte NIST vector, block 2 init_in=0
//    -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  - start_in pulsed at t=20 -> ignored, digest unchanged.
//  - rst_n low at t=30 -> IDLE; the following "abc" run is correct.
//  - SHA224_EN, mode_224_in=1, "abc"
//    -> H0..H6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.

Source files
------------

// File: rtl/sha256_compress.sv
// SHA-256 compression stage: consumes W_t (t = 0..63), runs the 64 rounds on
// working registers a..h, then folds the result into the chaining value H0..H7
// and presents the 256-bit digest. Blocks either chain from the current H or
// restart from the IV.
// Optional build macro SHA224_EN adds mode_224_in to select the SHA-224 IV.
module sha256_compress #(
    parameter int unsigned DATA_WIDTH = 32  // only 32 is meaningful (mod 2^32 arithmetic)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  init_in,
`ifdef SHA224_EN
    input  logic                  mode_224_in,
`endif
    input  logic                  w_valid_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  busy_out,
    output logic [5:0]            round_out,
    output logic                  digest_valid_out,
    output logic [255:0]          digest_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } state_t;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`ifdef SHA224_EN
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t       state;
    logic [31:0]  hv [8];   // chaining value H0..H7
    logic [31:0]  wk [8];   // working registers, wk[0] = a ... wk[7] = h
    logic [31:0]  iv_word [8];
    logic [31:0]  hsum [8];
    logic [255:0] hsum_packed;
    logic [31:0]  s0, s1, ch, maj, t1, t2;

    // IV selection for a block started with init_in
    always_comb begin
        logic [255:0] iv_sel;
        iv_sel = IV256;
`ifdef SHA224_EN
        if (mode_224_in) iv_sel = IV224;
`endif
        for (int unsigned i = 0; i < 8; i++) begin
            iv_word[i] = iv_sel[255 - 32*i -: 32];
        end
    end

    // One compression round on the current working registers
    always_comb begin
        s0  = {wk[0][1:0], wk[0][31:2]} ^ {wk[0][12:0], wk[0][31:13]} ^ {wk[0][21:0], wk[0][31:22]};
        s1  = {wk[4][5:0], wk[4][31:6]} ^ {wk[4][10:0], wk[4][31:11]} ^ {wk[4][24:0], wk[4][31:25]};
        ch  = (wk[4] & wk[5]) ^ (~wk[4] & wk[6]);
        maj = (wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]);
        t1  = wk[7] + s1 + ch + K[round_out] + w_in;
        t2  = s0 + maj;
    end

    // Chaining-value update applied in FINAL
    always_comb begin
        hsum_packed = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            hsum[i] = hv[i] + wk[i];
            hsum_packed[255 - 32*i -: 32] = hsum[i];
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            busy_out         <= 1'b0;
            round_out        <= '0;
            digest_valid_out <= 1'b0;
            digest_out       <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                hv[i] <= IV256[255 - 32*i -: 32];
                wk[i] <= '0;
            end
        end else begin
            digest_valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (init_in) begin
                                hv[i] <= iv_word[i];
                                wk[i] <= iv_word[i];
                            end else begin
                                wk[i] <= hv[i];
                            end
                        end
                        round_out <= '0;
                        busy_out  <= 1'b1;
                        state     <= ROUNDS;
                    end
                end
                ROUNDS: begin
                    if (w_valid_in) begin
                        // shift a..h down one slot, then overwrite e and a
                        for (int unsigned i = 1; i < 8; i++) begin
                            wk[i] <= wk[i-1];
                        end
                        wk[4]     <= wk[3] + t1;
                        wk[0]     <= t1 + t2;
                        round_out <= round_out + 6'd1;
                        if (round_out == 6'd63) state <= FINAL;
                    end
                end
                FINAL: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        hv[i] <= hsum[i];
                    end
                    digest_out       <= hsum_packed;
                    digest_valid_out <= 1'b1;
                    busy_out         <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: known-answer digests with the message
// schedule expanded locally, plus stall, busy-start, chaining and reset cases.
module tb_sha256_compress;

    logic         clk;
    logic         rst_n;
    logic         start_in;
    logic         init_in;
`ifdef SHA224_EN
    logic         mode_224_in;
`endif
    logic         w_valid_in;
    logic [31:0]  w_in;
    logic         busy_out;
    logic [5:0]   round_out;
    logic         digest_valid_out;
    logic [255:0] digest_out;

    sha256_compress #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .init_in          (init_in),
`ifdef SHA224_EN
        .mode_224_in      (mode_224_in),
`endif
        .w_valid_in       (w_valid_in),
        .w_in             (w_in),
        .busy_out         (busy_out),
        .round_out        (round_out),
        .digest_valid_out (digest_valid_out),
        .digest_out       (digest_out)
    );

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_NIST1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_NIST2 = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_NIST  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA224_EN
    localparam logic [223:0] DG_224   = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
`endif

    logic [31:0] wsch [64];
    int checks = 0;
    int passes = 0;
    int lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Fill W0..15 from a 512-bit block and expand W16..63
    task automatic load_block(input logic [511:0] blk);
        logic [31:0] sg0, sg1;
        for (int i = 0; i < 16; i++) wsch[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            sg0 = rotr(wsch[i-15], 7) ^ rotr(wsch[i-15], 18) ^ (wsch[i-15] >> 3);
            sg1 = rotr(wsch[i-2], 17) ^ rotr(wsch[i-2], 19) ^ (wsch[i-2] >> 10);
            wsch[i] = sg1 + wsch[i-7] + sg0 + wsch[i-16];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   busy_out, 0);
        check({tag, "_round"},  round_out, 0);
        check({tag, "_valid"},  digest_valid_out, 0);
        check({tag, "_digest"}, digest_out, 0);
    endtask

    // Run one block from the current negedge; lat = cycles from start cycle to pulse
    task automatic run_block(input logic init, input int stall_pct, input int start_at,
                             input int rst_at, output int lat_o);
        int  t, cyc, guard, round_err;
        logic v;
        lat_o = -1;
        start_in = 1'b1;
        init_in  = init;
        @(negedge clk);
        start_in = 1'b0;
        init_in  = 1'b0;
        cyc = 1;
        check("busy_after_start", busy_out, 1);
        t = 0; guard = 0; round_err = 0;
        while (t < 64 && guard < 1000) begin
            v = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            w_valid_in = v;
            w_in       = v ? wsch[t] : $urandom();
            start_in   = (t == start_at);
            init_in    = (t == start_at);
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals("midblock_reset");
                @(negedge clk);
                rst_n = 1'b1;
                w_valid_in = 1'b0;
                start_in = 1'b0;
                init_in = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
            guard++;
            if (v) t++;
            if (round_out != 6'(t)) round_err++;
        end
        w_valid_in = 1'b0;
        start_in   = 1'b0;
        init_in    = 1'b0;
        check("round_track", round_err, 0);
        guard = 0;
        while (!digest_valid_out && guard < 10) begin
            @(negedge clk);
            cyc++;
            guard++;
        end
        if (digest_valid_out) lat_o = cyc;
        check("pulse_seen", digest_valid_out, 1);
    endtask

    initial begin
        rst_n = 1'b0; start_in = 1'b0; init_in = 1'b0;
        w_valid_in = 1'b0; w_in = '0;
`ifdef SHA224_EN
        mode_224_in = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // w_valid_in must be ignored in IDLE
        w_valid_in = 1'b1; w_in = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        w_valid_in = 1'b0;
        check("idle_round", round_out, 0);
        check("idle_busy", busy_out, 0);

        // "abc", no stalls
        load_block(BLK_ABC);
        run_block(1'b1, 0, -1, -1, lat);
        check("abc_digest", digest_out, DG_ABC);
        check("abc_latency", lat, 66);
        check("final_busy_low", busy_out, 0);
        @(negedge clk);
        check("pulse_one_cycle", digest_valid_out, 0);
        check("digest_hold", digest_out, DG_ABC);

        // empty message
        load_block(BLK_EMPTY);
        run_block(1'b1, 0, -1, -1, lat);
        check("empty_digest", digest_out, DG_EMPTY);

        // "abc" with random stalls
        @(negedge clk);
        load_block(BLK_ABC);
        run_block(1'b1, 40, -1, -1, lat);
        check("abc_stall_digest", digest_out, DG_ABC);

        // two-block NIST vector, block 2 started in the pulse cycle and chained
        @(negedge clk);
        load_block(BLK_NIST1);
        run_block(1'b1, 0, -1, -1, lat);
        load_block(BLK_NIST2);
        run_block(1'b0, 0, -1, -1, lat);
        check("nist2_digest", digest_out, DG_NIST);

        // start_in with init while busy must not disturb the block
        @(negedge clk);
        load_block(BLK_ABC);
        run_block(1'b1, 0, 20, -1, lat);
        check("busy_start_digest", digest_out, DG_ABC);

        // reset mid-block, then a clean run
        @(negedge clk);
        load_block(BLK_EMPTY);
        run_block(1'b1, 0, -1, 30, lat);
        @(negedge clk);
        load_block(BLK_ABC);
        run_block(1'b1, 0, -1, -1, lat);
        check("post_reset_digest", digest_out, DG_ABC);

`ifdef SHA224_EN
        @(negedge clk);
        mode_224_in = 1'b1;
        load_block(BLK_ABC);
        run_block(1'b1, 0, -1, -1, lat);
        mode_224_in = 1'b0;
        check("sha224_digest", digest_out[255:32], DG_224);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
